// File: rtl/bus_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_cmd_master_if
// Brief    : Host-side command/response handshake bundle for bus_cmd_master.
// Revision : 1.0
// ============================================================================
interface bus_cmd_master_if;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdWrite;
  logic [15:0] CmdAddr;
  logic [7:0]  CmdData;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
  logic        CmdAutoInc;
`endif
  logic        RspValid;
  logic        RspReady;
  logic [7:0]  RspData;
  logic [15:0] RspAddr;

  modport master (
    input  CmdValid, CmdWrite, CmdAddr, CmdData,
`ifdef BUS_CMD_MASTER_AUTOINC_EN
    input  CmdAutoInc,
`endif
    output CmdReady,
    output RspValid, RspData, RspAddr,
    input  RspReady
  );

  modport slave (
    output CmdValid, CmdWrite, CmdAddr, CmdData,
`ifdef BUS_CMD_MASTER_AUTOINC_EN
    output CmdAutoInc,
`endif
    input  CmdReady,
    input  RspValid, RspData, RspAddr,
    output RspReady
  );
endinterface
`default_nettype wire

// File: rtl/bus_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_cmd_master
// Brief    : Buffers host read/write commands in a FIFO and runs them one at a
//            time on the shared register bus. Optional feature macro:
//            BUS_CMD_MASTER_AUTOINC_EN (address = last executed address + 1).
// Revision : 1.0
// ============================================================================
module bus_cmd_master #(
  parameter int          FIFO_AW   = 2,
  parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
  input  wire              BusClock,
  input  wire              Reset,
  bus_cmd_master_if.master cmd,
  output logic             Busy,
  output logic [15:0]      BusAddress,
  inout  wire  [7:0]       BusData,
  output logic             BusReadWrite
);
  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef struct packed {
`ifdef BUS_CMD_MASTER_AUTOINC_EN
    logic        auto_inc;
`endif
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR        = 3'd1,
    S_RD_ADDR   = 3'd2,
    S_RD_SAMPLE = 3'd3,
    S_RSP       = 3'd4
  } state_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               cmd_ready_q, cmd_ready_d;
  state_t             state_q, state_d;
  logic [15:0]        cur_addr_q, cur_addr_d;
  logic [7:0]         cur_data_q, cur_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [15:0]        rsp_addr_q, rsp_addr_d;
  logic [15:0]        bus_addr_q, bus_addr_d;
  logic               bus_rw_q, bus_rw_d;
  logic [7:0]         bus_wdata_q, bus_wdata_d;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
  logic [15:0]        last_addr_q, last_addr_d;
`endif

  logic               push;
  logic               pop;
  entry_t             entry_in;
  entry_t             head;
  logic [15:0]        exec_addr;

  always_comb begin
    entry_in.write = cmd.CmdWrite;
    entry_in.addr  = cmd.CmdAddr;
    entry_in.data  = cmd.CmdData;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
    entry_in.auto_inc = cmd.CmdAutoInc;
`endif
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    head        = mem_q[rd_ptr_q];
    exec_addr   = head.addr;
    pop         = 1'b0;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
    last_addr_d = last_addr_q;
    if (head.auto_inc) begin
      exec_addr = last_addr_q + 16'd1;
    end
`endif

    // Ready is registered, so a push can never land on a full FIFO.
    push = cmd.CmdValid && cmd_ready_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          cur_addr_d = exec_addr;
          cur_data_d = head.data;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
          last_addr_d = exec_addr;
`endif
          state_d    = head.write ? S_WR : S_RD_ADDR;
        end
      end
      S_WR:        state_d = S_IDLE;
      S_RD_ADDR:   state_d = S_RD_SAMPLE;
      S_RD_SAMPLE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = BusData;
        rsp_addr_d  = cur_addr_q;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (cmd.RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default:     state_d = S_IDLE;
    endcase

    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    cmd_ready_d = (count_d != CNT_FULL);

    // Bus outputs are registered from the next state so they change cleanly on the edge.
    bus_addr_d  = IDLE_ADDR;
    bus_rw_d    = 1'b0;
    bus_wdata_d = bus_wdata_q;
    case (state_d)
      S_WR: begin
        bus_addr_d  = cur_addr_d;
        bus_rw_d    = 1'b1;
        bus_wdata_d = cur_data_d;
      end
      S_RD_ADDR, S_RD_SAMPLE: bus_addr_d = cur_addr_d;
      default: ;
    endcase
  end

  always_ff @(posedge BusClock) begin
    if (!Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      bus_addr_q  <= IDLE_ADDR;
      bus_rw_q    <= 1'b0;
      bus_wdata_q <= '0;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
      last_addr_q <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      bus_addr_q  <= bus_addr_d;
      bus_rw_q    <= bus_rw_d;
      bus_wdata_q <= bus_wdata_d;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
      last_addr_q <= last_addr_d;
`endif
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge BusClock) begin
    mem_q <= mem_d;
  end

  assign cmd.CmdReady = cmd_ready_q;
  assign cmd.RspValid = rsp_valid_q;
  assign cmd.RspData  = rsp_data_q;
  assign cmd.RspAddr  = rsp_addr_q;
  assign Busy         = (count_q != '0) || (state_q != S_IDLE);
  assign BusAddress   = bus_addr_q;
  assign BusReadWrite = bus_rw_q;
  assign BusData      = bus_rw_q ? bus_wdata_q : 8'hzz;
endmodule
`default_nettype wire

// File: tb/tb_bus_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cmd_master
// Brief    : Directed and random checks of bus_cmd_master against a queue model
//            and a 16-register slave at addresses 0x0000..0x000F.
// Revision : 1.0
// ============================================================================
module tb_bus_cmd_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] bus_addr;
  wire  [7:0]  bus_data;
  logic        bus_rw;

  always #5 clk = ~clk;

  bus_cmd_master_if cmd_if ();

  bus_cmd_master #(.FIFO_AW(2), .IDLE_ADDR(16'hFFFF)) dut (
    .BusClock     (clk),
    .Reset        (rst_n),
    .cmd          (cmd_if.master),
    .Busy         (busy),
    .BusAddress   (bus_addr),
    .BusData      (bus_data),
    .BusReadWrite (bus_rw)
  );

  // Slave: latches writes at the edge, registers read data one edge ahead.
  logic [7:0] slave_regs [16];
  logic [7:0] slave_q;
  always @(posedge clk) begin
    if (bus_rw && bus_addr < 16'd16) slave_regs[bus_addr[3:0]] <= bus_data;
    slave_q <= slave_regs[bus_addr[3:0]];
  end
  assign bus_data = (!bus_rw && bus_addr < 16'd16) ? slave_q : 8'hzz;

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  cmd_t       exp_q[$];
  logic [7:0] model_mem [16];
`ifdef BUS_CMD_MASTER_AUTOINC_EN
  logic [15:0] model_last = 16'd0;
`endif
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: commands in acceptance order, executed strictly in order.
  always @(negedge clk) begin
    cmd_t c;
    if (!rst_n) begin
      exp_q.delete();
`ifdef BUS_CMD_MASTER_AUTOINC_EN
      model_last = 16'd0;
`endif
    end else begin
      if (bus_rw) begin
        if (exp_q.size() == 0) chk("unexpected_bus_write", 1, 0);
        else begin
          chk("mon_wr_kind", exp_q[0].write, 1);
          chk("mon_wr_addr", bus_addr, exp_q[0].addr);
          chk("mon_wr_data", bus_data, exp_q[0].data);
          if (exp_q[0].addr < 16'd16) model_mem[exp_q[0].addr[3:0]] = exp_q[0].data;
          void'(exp_q.pop_front());
        end
      end else if (bus_addr != 16'hFFFF) begin
        if (exp_q.size() == 0) chk("unexpected_bus_read", 1, 0);
        else begin
          chk("mon_rd_kind", exp_q[0].write, 0);
          chk("mon_rd_addr", bus_addr, exp_q[0].addr);
        end
      end
      if (cmd_if.RspValid && cmd_if.RspReady) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          chk("mon_rsp_kind", exp_q[0].write, 0);
          chk("mon_rsp_addr", cmd_if.RspAddr, exp_q[0].addr);
          if (exp_q[0].addr < 16'd16)
            chk("mon_rsp_data", cmd_if.RspData, model_mem[exp_q[0].addr[3:0]]);
          void'(exp_q.pop_front());
        end
      end
      if (cmd_if.CmdValid && cmd_if.CmdReady) begin
        c.write = cmd_if.CmdWrite;
        c.addr  = cmd_if.CmdAddr;
        c.data  = cmd_if.CmdData;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
        if (cmd_if.CmdAutoInc) c.addr = model_last + 16'd1;
        model_last = c.addr;
`endif
        exp_q.push_back(c);
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted it.
  task automatic push_cmd(input bit w, input logic [15:0] a, input logic [7:0] d);
    bit done = 1'b0;
    cmd_if.CmdValid = 1'b1;
    cmd_if.CmdWrite = w;
    cmd_if.CmdAddr  = a;
    cmd_if.CmdData  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = cmd_if.CmdReady;
      @(posedge clk);
      #1;
    end
    cmd_if.CmdValid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("wait_idle", idle, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit   found;
    bit   acc;
    int   sent;
    for (int i = 0; i < 16; i++) begin
      slave_regs[i] = 8'h00;
      model_mem[i]  = 8'h00;
    end
    slave_q = 8'h00;
    cmd_if.CmdValid = 1'b0;
    cmd_if.CmdWrite = 1'b0;
    cmd_if.CmdAddr  = 16'h0;
    cmd_if.CmdData  = 8'h0;
    cmd_if.RspReady = 1'b0;
`ifdef BUS_CMD_MASTER_AUTOINC_EN
    cmd_if.CmdAutoInc = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_if.CmdReady, 0);
    chk("rst_rsp_valid", cmd_if.RspValid, 0);
    chk("rst_rsp_data", cmd_if.RspData, 8'h00);
    chk("rst_rsp_addr", cmd_if.RspAddr, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_bus_addr", bus_addr, 16'hFFFF);
    chk("rst_bus_rw", bus_rw, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", cmd_if.CmdReady, 1);
    @(posedge clk);
    #1;

    // Single write, exactly one bus cycle then re-parked
    push_cmd(1'b1, 16'h0001, 8'h40);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = bus_rw;
    end
    chk("wr_seen", found, 1);
    chk("wr_addr", bus_addr, 16'h0001);
    chk("wr_data", bus_data, 8'h40);
    @(negedge clk);
    chk("wr_park_addr", bus_addr, 16'hFFFF);
    chk("wr_park_rw", bus_rw, 0);
    @(posedge clk);
    #1;

    // Write then read back, response latency and stall
    push_cmd(1'b1, 16'h0003, 8'h80);
    push_cmd(1'b0, 16'h0003, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = !bus_rw && bus_addr == 16'h0003;
    end
    chk("rd_addr_seen", found, 1);
    chk("rd_lat0_valid", cmd_if.RspValid, 0);
    @(negedge clk);
    chk("rd_lat1_valid", cmd_if.RspValid, 0);
    @(negedge clk);
    chk("rd_lat2_valid", cmd_if.RspValid, 1);
    chk("rd_data", cmd_if.RspData, 8'h80);
    chk("rd_rsp_addr", cmd_if.RspAddr, 16'h0003);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", cmd_if.RspValid, 1);
      chk("stall_data", cmd_if.RspData, 8'h80);
      chk("stall_addr", cmd_if.RspAddr, 16'h0003);
      chk("stall_parked", bus_addr, 16'hFFFF);
    end
    @(posedge clk);
    #1 cmd_if.RspReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rsp_drop", cmd_if.RspValid, 0);
    @(posedge clk);
    #1 cmd_if.RspReady = 1'b0;
    wait_idle();

    // FIFO full while the FSM is stalled in RSP
    push_cmd(1'b0, 16'h0003, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = cmd_if.RspValid;
    end
    chk("stall_rsp_seen", found, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cmd_if.CmdValid = 1'b1;
      cmd_if.CmdWrite = 1'b1;
      cmd_if.CmdAddr  = 16'(4 + i);
      cmd_if.CmdData  = 8'($urandom);
      @(negedge clk);
      chk("fill_ready", cmd_if.CmdReady, 1);
      @(posedge clk);
      #1;
    end
    cmd_if.CmdAddr = 16'h0008;
    cmd_if.CmdData = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      chk("full_ready_low", cmd_if.CmdReady, 0);
      @(posedge clk);
      #1;
    end
    cmd_if.RspReady = 1'b1;
    @(negedge clk);
    chk("full_at_rsp_accept", cmd_if.CmdReady, 0);
    @(posedge clk);
    #1 cmd_if.RspReady = 1'b0;
    @(negedge clk);
    chk("full_no_comb_ready", cmd_if.CmdReady, 0);
    @(negedge clk);
    chk("fifth_accept", cmd_if.CmdReady, 1);
    @(posedge clk);
    #1 cmd_if.CmdValid = 1'b0;
    wait_idle();

    // Reset during RD_SAMPLE with two commands queued
    cmd_if.CmdValid = 1'b1;
    cmd_if.CmdWrite = 1'b0;
    cmd_if.CmdAddr  = 16'h0004;
    @(negedge clk);
    chk("abort_push_rd", cmd_if.CmdReady, 1);
    @(posedge clk);
    #1;
    cmd_if.CmdWrite = 1'b1;
    cmd_if.CmdAddr  = 16'h0009;
    cmd_if.CmdData  = 8'h99;
    @(negedge clk);
    chk("abort_push_w1", cmd_if.CmdReady, 1);
    @(posedge clk);
    #1;
    cmd_if.CmdAddr = 16'h000A;
    cmd_if.CmdData = 8'hAA;
    @(negedge clk);
    chk("abort_push_w2", cmd_if.CmdReady, 1);
    chk("abort_rd_addr", bus_addr, 16'h0004);
    @(posedge clk);
    #1;
    cmd_if.CmdValid = 1'b0;
    rst_n = 1'b0;
    chk("abort_in_rd_sample", bus_addr, 16'h0004);
    chk("abort_busy_before", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", cmd_if.RspValid, 0);
    chk("abort_bus_addr", bus_addr, 16'hFFFF);
    chk("abort_bus_rw", bus_rw, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("abort_stays_parked", bus_addr, 16'hFFFF);
    end
    chk("abort_no_busy", busy, 0);
    @(posedge clk);
    #1;

`ifdef BUS_CMD_MASTER_AUTOINC_EN
    // Auto-increment wraps from 0xFFFF to 0x0000
    push_cmd(1'b1, 16'hFFFF, 8'h11);
    cmd_if.CmdAutoInc = 1'b1;
    push_cmd(1'b1, 16'h1234, 8'h22);
    cmd_if.CmdAutoInc = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus_rw && bus_data == 8'h22;
    end
    chk("autoinc_seen", found, 1);
    chk("autoinc_wrap_addr", bus_addr, 16'h0000);
    @(posedge clk);
    #1;
    wait_idle();
`endif

    // Random traffic with random response back-pressure
    sent = 0;
    acc  = 1'b0;
    for (int cyc = 0; cyc < 3000 && sent < 60; cyc++) begin
      if (!cmd_if.CmdValid || acc) begin
        if ($urandom_range(3) != 0) begin
          cmd_if.CmdValid = 1'b1;
          cmd_if.CmdWrite = 1'($urandom_range(1));
          cmd_if.CmdAddr  = 16'($urandom_range(15));
          cmd_if.CmdData  = 8'($urandom);
        end else begin
          cmd_if.CmdValid = 1'b0;
        end
      end
      cmd_if.RspReady = ($urandom_range(2) != 0);
      @(negedge clk);
      acc = cmd_if.CmdValid && cmd_if.CmdReady;
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    cmd_if.CmdValid = 1'b0;
    cmd_if.RspReady = 1'b1;
    chk("random_all_sent", sent, 60);
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
